clusterv_tile_sram_arbiter: RTL and testbench
=============================================

CLUSTERV_TILE_SRAM_ARBITER -- requirements
Module: clusterv_tile_sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width of all requester and target address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; the byte-mask width SHALL be DATA_WIDTH/8.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 iN_req  input  1  (N=0,1) SHALL be the requester N access request.
REQ-006 iN_we  input  1  SHALL select write (1) or read (0).
REQ-007 iN_wmask  input  DATA_WIDTH/8  SHALL be the write byte enables.
REQ-008 iN_addr  input  ADDR_WIDTH  SHALL be the word address.
REQ-009 iN_dat_w  input  DATA_WIDTH  SHALL be the write data.
REQ-010 iN_gnt  output  1  SHALL indicate that the access is accepted this cycle.
REQ-011 iN_rvalid  output  1  SHALL mark valid read data on iN_dat_r.
REQ-012 iN_dat_r  output  DATA_WIDTH  SHALL be the read data for requester N.
REQ-013 t_csb, t_web  output  1 each  SHALL be the active-low SRAM chip select and write enable.
REQ-014 t_wmask  output  DATA_WIDTH/8;  t_addr  output  ADDR_WIDTH;  t_dat_w  output  DATA_WIDTH  SHALL drive the SRAM RW port.
REQ-015 t_dat_r  input  DATA_WIDTH  SHALL be the SRAM read data, valid one cycle after the read cycle.

Function
REQ-016 Requester N SHALL hold iN_req and all its request fields stable until the cycle in which iN_gnt=1 is sampled.
REQ-017 Grant SHALL be combinational from the current iN_req and the registered priority pointer; at most one iN_gnt SHALL be 1 per cycle.
REQ-018 Single request: the arbiter SHALL grant it in the same cycle, regardless of the pointer.
REQ-019 Both requesting: the arbiter SHALL grant the port named by the pointer, and the other port SHALL see iN_gnt=0.
REQ-020 After any grant to port k, the pointer SHALL move to port 1-k; with no grant it SHALL hold. The worst-case wait SHALL be one granted access.
REQ-021 Granted cycle: t_csb=0, t_web=~iN_we, and t_addr/t_wmask/t_dat_w SHALL be the winner's fields, combinationally.
REQ-022 No grant: t_csb=1, t_web=1, t_wmask=0, t_addr=0, t_dat_w=0.
REQ-023 Granted reads SHALL force t_wmask=0 at the target.
REQ-024 Granted read at cycle C: the arbiter SHALL register the pending port, and at C+1 it SHALL assert iN_rvalid=1 for that port only, with iN_dat_r=t_dat_r passed through unregistered.
REQ-025 iN_dat_r SHALL be 0 whenever iN_rvalid=0.
REQ-026 Back-to-back reads SHALL sustain one access per cycle; a read return and a new grant in the same cycle SHALL both proceed.
REQ-027 A granted write with iN_wmask=0 SHALL still issue the SRAM cycle (t_csb=0, t_web=0) and SHALL produce no rvalid.
REQ-028 Writes SHALL produce no response beyond iN_gnt.

Reset
REQ-029 While reset=0: all iN_gnt=0, all iN_rvalid=0, iN_dat_r=0, target outputs at idle values (REQ-022), pointer=port 0.
REQ-030 Assertion mid-operation SHALL asynchronously clear the pending-read register; a read granted in the cycle before reset SHALL never return rvalid.
REQ-031 After deassertion, the first cycle with both requests pending SHALL grant port 0.

Verification
REQ-032 Reset release, i0 read addr 0x05 alone -> i0_gnt=1 same cycle, t_csb=0, t_web=1, t_addr=0x05; next cycle i0_rvalid=1, i0_dat_r=t_dat_r.
REQ-033 Both request continuously for 4 cycles -> grants alternate 0,1,0,1, and t_addr follows the winner each cycle.
REQ-034 i1 write addr 0x10, wmask 4'b0101, data 0xA5A5A5A5, then i0 read 0x10 -> read returns 0x00A500A5 over a preloaded zero word.
REQ-035 i0 read granted, reset asserted in the next cycle before the clock edge -> i0_rvalid stays 0, and t_csb=1 during reset.
REQ-036 i0 write with wmask 0 -> t_csb=0, t_web=0, t_wmask=0, no rvalid on either port, and the pointer moves to port 1.

Source files
------------

// File: rtl/clusterv_tile_sram_arbiter_if.sv
// Two-requester SRAM port bundle for the tile arbiter.
// Requester side: iN_req, iN_we, iN_wmask, iN_addr, iN_dat_w in; iN_gnt, iN_rvalid, iN_dat_r out.
// Target side:    t_csb, t_web, t_wmask, t_addr, t_dat_w out; t_dat_r in (one cycle after a read).
// slave  = arbiter view, master = environment (requesters plus SRAM macro) view.
interface clusterv_tile_sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  // requester 0
  logic                  i0_req;
  logic                  i0_we;
  logic [MASK_WIDTH-1:0] i0_wmask;
  logic [ADDR_WIDTH-1:0] i0_addr;
  logic [DATA_WIDTH-1:0] i0_dat_w;
  logic                  i0_gnt;
  logic                  i0_rvalid;
  logic [DATA_WIDTH-1:0] i0_dat_r;

  // requester 1
  logic                  i1_req;
  logic                  i1_we;
  logic [MASK_WIDTH-1:0] i1_wmask;
  logic [ADDR_WIDTH-1:0] i1_addr;
  logic [DATA_WIDTH-1:0] i1_dat_w;
  logic                  i1_gnt;
  logic                  i1_rvalid;
  logic [DATA_WIDTH-1:0] i1_dat_r;

  // SRAM RW port
  logic                  t_csb;
  logic                  t_web;
  logic [MASK_WIDTH-1:0] t_wmask;
  logic [ADDR_WIDTH-1:0] t_addr;
  logic [DATA_WIDTH-1:0] t_dat_w;
  logic [DATA_WIDTH-1:0] t_dat_r;

  modport slave (
    input  i0_req, i0_we, i0_wmask, i0_addr, i0_dat_w,
    input  i1_req, i1_we, i1_wmask, i1_addr, i1_dat_w,
    input  t_dat_r,
    output i0_gnt, i0_rvalid, i0_dat_r,
    output i1_gnt, i1_rvalid, i1_dat_r,
    output t_csb, t_web, t_wmask, t_addr, t_dat_w
  );

  modport master (
    output i0_req, i0_we, i0_wmask, i0_addr, i0_dat_w,
    output i1_req, i1_we, i1_wmask, i1_addr, i1_dat_w,
    output t_dat_r,
    input  i0_gnt, i0_rvalid, i0_dat_r,
    input  i1_gnt, i1_rvalid, i1_dat_r,
    input  t_csb, t_web, t_wmask, t_addr, t_dat_w
  );
endinterface

// File: rtl/clusterv_tile_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// Ports:
//   clock - single clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - arbiter (slave) view of the requester and SRAM signal bundle
// Grant and target drive are combinational from the requests and the
// registered priority pointer; a read granted in cycle C returns rvalid and
// the raw SRAM read data in cycle C+1.
module clusterv_tile_sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  clusterv_tile_sram_arbiter_if.slave   bus
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e ptr_q, ptr_d;           // port that wins when both request
  logic  rd_pend_q, rd_pend_d;   // read issued last cycle, data due now
  port_e rd_port_q, rd_port_d;   // requester owning the pending read

  logic                  gnt0_c;
  logic                  gnt1_c;
  logic                  t_csb_c;
  logic                  t_web_c;
  logic [MASK_WIDTH-1:0] t_wmask_c;
  logic [ADDR_WIDTH-1:0] t_addr_c;
  logic [DATA_WIDTH-1:0] t_dat_w_c;
  logic                  rvalid0_c;
  logic                  rvalid1_c;

  // State registers: pointer and pending-read tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q     <= PORT0;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // Arbitration and next-state; grants are held off while reset is asserted
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    ptr_d     = ptr_q;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;

    if (reset) begin
      if (bus.i0_req && (!bus.i1_req || (ptr_q == PORT0))) begin
        gnt0_c = 1'b1;
      end else if (bus.i1_req) begin
        gnt1_c = 1'b1;
      end
    end

    if (gnt0_c) begin
      ptr_d     = PORT1;
      rd_pend_d = !bus.i0_we;
      rd_port_d = PORT0;
    end else if (gnt1_c) begin
      ptr_d     = PORT0;
      rd_pend_d = !bus.i1_we;
      rd_port_d = PORT1;
    end
  end

  // Target port mux; idle values when nothing is granted, reads never write bytes
  always_comb begin
    t_csb_c   = 1'b1;
    t_web_c   = 1'b1;
    t_wmask_c = '0;
    t_addr_c  = '0;
    t_dat_w_c = '0;

    if (gnt0_c) begin
      t_csb_c   = 1'b0;
      t_web_c   = !bus.i0_we;
      t_wmask_c = bus.i0_we ? bus.i0_wmask : MASK_WIDTH'(0);
      t_addr_c  = bus.i0_addr;
      t_dat_w_c = bus.i0_dat_w;
    end else if (gnt1_c) begin
      t_csb_c   = 1'b0;
      t_web_c   = !bus.i1_we;
      t_wmask_c = bus.i1_we ? bus.i1_wmask : MASK_WIDTH'(0);
      t_addr_c  = bus.i1_addr;
      t_dat_w_c = bus.i1_dat_w;
    end
  end

  // Read return: SRAM data is steered, unregistered, to the owner of the pending read
  assign rvalid0_c = rd_pend_q && (rd_port_q == PORT0);
  assign rvalid1_c = rd_pend_q && (rd_port_q == PORT1);

  assign bus.i0_gnt    = gnt0_c;
  assign bus.i1_gnt    = gnt1_c;
  assign bus.i0_rvalid = rvalid0_c;
  assign bus.i1_rvalid = rvalid1_c;
  assign bus.i0_dat_r  = rvalid0_c ? bus.t_dat_r : DATA_WIDTH'(0);
  assign bus.i1_dat_r  = rvalid1_c ? bus.t_dat_r : DATA_WIDTH'(0);

  assign bus.t_csb     = t_csb_c;
  assign bus.t_web     = t_web_c;
  assign bus.t_wmask   = t_wmask_c;
  assign bus.t_addr    = t_addr_c;
  assign bus.t_dat_w   = t_dat_w_c;

endmodule

// File: tb/tb_clusterv_tile_sram_arbiter.sv
// Directed bench for the two-port SRAM arbiter with a behavioural SRAM behind it.
module tb_clusterv_tile_sram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 16;

  logic clock;
  logic reset;

  clusterv_tile_sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  clusterv_tile_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM: masked write, registered read data
  logic [DW-1:0] mem [256];

  always @(posedge clock) begin
    if (!bus.t_csb) begin
      if (!bus.t_web) begin
        for (int b = 0; b < 4; b++)
          if (bus.t_wmask[b]) mem[bus.t_addr][8*b +: 8] <= bus.t_dat_w[8*b +: 8];
      end else begin
        bus.t_dat_r <= mem[bus.t_addr];
      end
    end
  end

  typedef struct {
    logic          r0, w0;
    logic [3:0]    m0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [3:0]    m1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [1:0]    gnt;   // {i1_gnt, i0_gnt}
    logic          csb, web;
    logic [AW-1:0] ta;
    logic [3:0]    tm;
    logic [DW-1:0] td;
    logic [1:0]    rv;    // {i1_rvalid, i0_rvalid}
    logic [DW-1:0] dr0, dr1;
  } vec_t;

  vec_t vecs [NV];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic apply(input vec_t v);
    bus.i0_req = v.r0; bus.i0_we = v.w0; bus.i0_wmask = v.m0; bus.i0_addr = v.a0; bus.i0_dat_w = v.d0;
    bus.i1_req = v.r1; bus.i1_we = v.w1; bus.i1_wmask = v.m1; bus.i1_addr = v.a1; bus.i1_dat_w = v.d1;
  endtask

  function automatic logic [127:0] got_gnt();
    return 128'({bus.i1_gnt, bus.i0_gnt});
  endfunction

  function automatic logic [127:0] got_tgt();
    return 128'({bus.t_csb, bus.t_web, bus.t_addr, bus.t_wmask, bus.t_dat_w});
  endfunction

  function automatic logic [127:0] got_rsp();
    return 128'({bus.i1_rvalid, bus.i0_rvalid, bus.i0_dat_r, bus.i1_dat_r});
  endfunction

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [3:0] m0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic [3:0] m1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic [1:0] gnt, input logic csb, input logic web, input logic [AW-1:0] ta, input logic [3:0] tm,
    input logic [DW-1:0] td, input logic [1:0] rv, input logic [DW-1:0] dr0, input logic [DW-1:0] dr1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.m0 = m0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.m1 = m1; v.a1 = a1; v.d1 = d1;
    v.gnt = gnt; v.csb = csb; v.web = web; v.ta = ta; v.tm = tm; v.td = td;
    v.rv = rv; v.dr0 = dr0; v.dr1 = dr1;
    return v;
  endfunction

  vec_t idle_v;

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 256; i++) mem[i] = {24'hA0B1C2, 8'(i)};
    mem[8'h10] = 32'h0;
    bus.t_dat_r = '0;

    idle_v = mk(1'b0,1'b0,4'h0,8'h00,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,
                2'b00,1'b1,1'b1,8'h00,4'h0,32'h0, 2'b00,32'h0,32'h0);

    //             i0: req we mask addr data             i1: req we mask addr data              gnt csb web taddr tmask tdata          rv  dat_r0 dat_r1
    vecs[0]  = idle_v;
    vecs[1]  = mk(1'b1,1'b0,4'h0,8'h05,32'h0,        1'b0,1'b0,4'h0,8'h00,32'h0,        2'b01,1'b0,1'b1,8'h05,4'h0,32'h0,        2'b00,32'h0,32'h0);
    vecs[2]  = mk(1'b1,1'b0,4'h0,8'h07,32'h0,        1'b0,1'b0,4'h0,8'h00,32'h0,        2'b01,1'b0,1'b1,8'h07,4'h0,32'h0,        2'b01,32'hA0B1C205,32'h0);
    vecs[3]  = mk(1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b0,4'h0,8'h06,32'h0,        2'b10,1'b0,1'b1,8'h06,4'h0,32'h0,        2'b01,32'hA0B1C207,32'h0);
    vecs[4]  = mk(1'b1,1'b0,4'h0,8'h20,32'h0,        1'b1,1'b0,4'h0,8'h21,32'h0,        2'b01,1'b0,1'b1,8'h20,4'h0,32'h0,        2'b10,32'h0,32'hA0B1C206);
    vecs[5]  = mk(1'b1,1'b0,4'h0,8'h20,32'h0,        1'b1,1'b0,4'h0,8'h21,32'h0,        2'b10,1'b0,1'b1,8'h21,4'h0,32'h0,        2'b01,32'hA0B1C220,32'h0);
    vecs[6]  = mk(1'b1,1'b0,4'h0,8'h20,32'h0,        1'b1,1'b0,4'h0,8'h21,32'h0,        2'b01,1'b0,1'b1,8'h20,4'h0,32'h0,        2'b10,32'h0,32'hA0B1C221);
    vecs[7]  = mk(1'b1,1'b0,4'h0,8'h20,32'h0,        1'b1,1'b0,4'h0,8'h21,32'h0,        2'b10,1'b0,1'b1,8'h21,4'h0,32'h0,        2'b01,32'hA0B1C220,32'h0);
    vecs[8]  = mk(1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b1,4'h5,8'h10,32'hA5A5A5A5, 2'b10,1'b0,1'b0,8'h10,4'h5,32'hA5A5A5A5, 2'b10,32'h0,32'hA0B1C221);
    vecs[9]  = mk(1'b1,1'b0,4'h0,8'h10,32'h0,        1'b0,1'b0,4'h0,8'h00,32'h0,        2'b01,1'b0,1'b1,8'h10,4'h0,32'h0,        2'b00,32'h0,32'h0);
    vecs[10] = idle_v;
    vecs[10].rv  = 2'b01;
    vecs[10].dr0 = 32'h00A500A5;
    vecs[11] = mk(1'b1,1'b1,4'h0,8'h30,32'h12345678, 1'b0,1'b0,4'h0,8'h00,32'h0,        2'b01,1'b0,1'b0,8'h30,4'h0,32'h12345678, 2'b00,32'h0,32'h0);
    vecs[12] = mk(1'b1,1'b0,4'h0,8'h20,32'h0,        1'b1,1'b0,4'h0,8'h21,32'h0,        2'b10,1'b0,1'b1,8'h21,4'h0,32'h0,        2'b00,32'h0,32'h0);
    vecs[13] = idle_v;
    vecs[13].rv  = 2'b10;
    vecs[13].dr1 = 32'hA0B1C221;
    vecs[14] = mk(1'b1,1'b0,4'hF,8'h22,32'hDEADBEEF, 1'b0,1'b0,4'h0,8'h00,32'h0,        2'b01,1'b0,1'b1,8'h22,4'h0,32'hDEADBEEF, 2'b00,32'h0,32'h0);
    vecs[15] = idle_v;
    vecs[15].rv  = 2'b01;
    vecs[15].dr0 = 32'hA0B1C222;

    // Reset held with both ports requesting: everything idle
    reset = 1'b0;
    apply(mk(1'b1,1'b0,4'h0,8'h01,32'h0, 1'b1,1'b0,4'h0,8'h02,32'h0,
             2'b00,1'b1,1'b1,8'h00,4'h0,32'h0, 2'b00,32'h0,32'h0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset gnt", got_gnt(), 128'(2'b00));
    check("reset target", got_tgt(), 128'({1'b1, 1'b1, 8'h00, 4'h0, 32'h0}));
    check("reset rsp", got_rsp(), 128'({2'b00, 32'h0, 32'h0}));
    apply(idle_v);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Table-driven sequence, one vector per cycle
    for (int i = 0; i < int'(NV); i++) begin
      apply(vecs[i]);
      @(negedge clock);
      check($sformatf("vec%0d gnt", i), got_gnt(), 128'(vecs[i].gnt));
      check($sformatf("vec%0d target", i), got_tgt(),
            128'({vecs[i].csb, vecs[i].web, vecs[i].ta, vecs[i].tm, vecs[i].td}));
      check($sformatf("vec%0d rsp", i), got_rsp(),
            128'({vecs[i].rv, vecs[i].dr0, vecs[i].dr1}));
      @(posedge clock);
      #1;
    end

    // Read granted, reset asserted before the next edge: read must never return
    apply(mk(1'b1,1'b0,4'h0,8'h05,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,
             2'b00,1'b1,1'b1,8'h00,4'h0,32'h0, 2'b00,32'h0,32'h0));
    @(negedge clock);
    check("pre-reset read gnt", got_gnt(), 128'(2'b01));
    #2;
    reset = 1'b0;
    #1;
    check("mid reset gnt", got_gnt(), 128'(2'b00));
    check("mid reset csb", 128'(bus.t_csb), 128'(1'b1));
    @(posedge clock);
    #1;
    check("aborted read rsp in reset", got_rsp(), 128'({2'b00, 32'h0, 32'h0}));
    apply(idle_v);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("aborted read rsp after reset", got_rsp(), 128'({2'b00, 32'h0, 32'h0}));

    // First contended cycle after reset goes to port 0
    apply(mk(1'b1,1'b0,4'h0,8'h20,32'h0, 1'b1,1'b0,4'h0,8'h21,32'h0,
             2'b00,1'b1,1'b1,8'h00,4'h0,32'h0, 2'b00,32'h0,32'h0));
    @(negedge clock);
    check("post-reset contend gnt", got_gnt(), 128'(2'b01));
    @(posedge clock);
    #1;
    apply(idle_v);
    check("post-reset read rsp", got_rsp(), 128'({2'b01, 32'hA0B1C220, 32'h0}));

    // Reset while rvalid is showing: it must drop without waiting for an edge
    reset = 1'b0;
    #1;
    check("async clear rsp", got_rsp(), 128'({2'b00, 32'h0, 32'h0}));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
